gcd_unit_multimode: RTL and testbench
=====================================

# gcd_unit_multimode

Parametrised, dual-algorithm GCD unit. It is the successor to the fixed 16-bit subtract-swap GCD unit. It adds a width parameter, a per-transaction selection between Euclid subtract-swap and binary (Stein) algorithms, and a per-result compute-cycle count. It sits between a val/rdy operand source and a val/rdy result sink and drops into the existing test-source/test-sink harness.

## Interface
- W, default 16: operand/result width (≥2)
- CW, default 8: width of cycle-count output (≥1)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- operands_bits_A  in  W  operand A
- operands_bits_B  in  W  operand B
- operands_mode  in  1  algorithm select: 0 = Euclid subtract-swap, 1 = binary Stein
- operands_val  in  1  operands valid
- operands_rdy  out  1  unit ready to accept operands
- result_bits_data  out  W  GCD result
- result_bits_cycles  out  CW  CALC cycles spent on this result, saturating
- result_val  out  1  result valid
- result_rdy  in  1  sink ready

## Operation
- States: IDLE, CALC, DONE. All outputs are registered or decoded from state.
- Reset while asserted: state=IDLE, operands_rdy=1, result_val=0, result_bits_data=0, result_bits_cycles=0, A=B=k=cnt=0. Operand fire is suppressed while reset is high.
- IDLE: operands_rdy=1. On operands_val&&operands_rdy, latch A, B and mode, clear k and cnt, then go to CALC.
- CALC: operands_rdy=0 and result_val=0. Each cycle does cnt = min(cnt+1, 2^CW−1) and exactly one step.
- Euclid step (mode 0), first match wins:
  - A<B: swap A and B.
  - else B≠0: A=A−B.
  - else: terminate with result A.
- Stein step (mode 1), first match wins:
  - A==0: terminate with result B<<k.
  - B==0: terminate with result A<<k.
  - A and B both even: A>>=1, B>>=1, k++.
  - A even: A>>=1.
  - B even: B>>=1.
  - Both odd, A≥B: A=A−B.
  - Both odd, otherwise: B=B−A.
- k width is clog2(W)+1. The shifted result never exceeds the larger original operand, so no overflow.
- Terminate: load result_bits_data with the result and result_bits_cycles with the incremented cnt (it includes the terminating cycle), then go to DONE.
- DONE: result_val=1. Data and cycles are held stable. On result_val&&result_rdy, go to IDLE.
- Defined edge results: gcd(0,0)=0, gcd(x,0)=gcd(0,x)=x in both modes.
- All arithmetic is unsigned, W bits wide. A subtract step never underflows.

## Timing
- Operand fire at edge e0 puts the unit in CALC from e0. With N terminal cycles, result_val rises at edge e0+N. result_bits_cycles=N (saturated at 2^CW−1).
- Fire-to-result_val latency equals result_bits_cycles when not saturated.
- There is no overlap. operands_rdy stays 0 from the fire edge until the edge after the result fires. The earliest next fire is one cycle after the result handshake, so peak throughput is one result per N+2 cycles.
- result_val does not depend combinationally on result_rdy. operands_rdy does not depend combinationally on operands_val.
- Async reset mid-CALC or in DONE aborts immediately: no result is emitted, all outputs take their reset values, and the in-flight operands are lost.
- Backpressure in DONE is unbounded. Outputs are held stable without change.

## Test plan
- Euclid, W=16: (27,15)→3, (21,49)→7, (25,30)→5, (19,27)→1, (250,190)→10, (5,250)→5 sent back-to-back. Each result matches, and the count matches a reference model.
- Euclid, W=16: (40,40)→data 40, cycles 3. (0,0)→data 0, cycles 1.
- Stein, W=16: (40,40)→data 40, cycles 5. (0,7)→data 7, cycles 1. (250,190)→10.
- W=32, CW=4: Stein (0xFFFFFFFE,0x80000000)→2. Euclid (250,1)→data 1, cycles 15 (saturated).
- Backpressure: hold result_rdy=0 for 10 cycles after result_val. result_val stays 1, data and cycles stay stable, and operands_rdy stays 0. The result fires when rdy is released, and operands_rdy=1 on the next cycle.
- Reset mid-operation: fire Euclid (250,1), assert reset 20 cycles later. Outputs go to reset values immediately. After release, (27,15)→3 completes correctly with no stale result.

Source files
------------

// File: rtl/gcd_unit_multimode.sv
`default_nettype none
// ============================================================================
// Module   : gcd_unit_multimode
// Purpose  : Parametrised GCD engine with a per-transaction choice between
//            Euclid subtract-swap and binary (Stein) algorithms. It also
//            reports how many compute cycles each result took, saturating at
//            the top of the count range.
//
// Ports    : clk                 - clock, all state updates on rising edge
//            reset               - asynchronous active-high reset
//            operands_bits_A/B   - W-bit unsigned operands
//            operands_mode       - 0 = Euclid subtract-swap, 1 = Stein
//            operands_val/rdy    - operand handshake (rdy high only in IDLE)
//            result_bits_data    - W-bit GCD result
//            result_bits_cycles  - CW-bit compute-cycle count, saturating
//            result_val/rdy      - result handshake (val high only in DONE)
//
// Revision : 1.0 - initial release
// ============================================================================
module gcd_unit_multimode #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  operands_bits_A,
    input  logic [W-1:0]  operands_bits_B,
    input  logic          operands_mode,
    input  logic          operands_val,
    output logic          operands_rdy,
    output logic [W-1:0]  result_bits_data,
    output logic [CW-1:0] result_bits_cycles,
    output logic          result_val,
    input  logic          result_rdy
);

    // Common power-of-two exponent k needs to reach at most W-1.
    localparam int             c_KW        = $clog2(W) + 1;
    localparam logic [1:0]     c_ST_IDLE   = 2'd0;
    localparam logic [1:0]     c_ST_CALC   = 2'd1;
    localparam logic [1:0]     c_ST_DONE   = 2'd2;
    localparam logic [CW-1:0]  c_CNT_MAX   = '1;
    localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);
    localparam logic [c_KW-1:0] c_K_ONE    = c_KW'(1);

    logic [1:0]      r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_mode;
    logic [c_KW-1:0] r_k;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_data;
    logic [CW-1:0]   r_cycles;

    logic [1:0]      w_state_nxt;
    logic [W-1:0]    w_a_nxt;
    logic [W-1:0]    w_b_nxt;
    logic            w_mode_nxt;
    logic [c_KW-1:0] w_k_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [W-1:0]    w_data_nxt;
    logic [CW-1:0]   w_cycles_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_term;
    logic [W-1:0]    w_res;

    // Outputs are decoded from state or come straight from registers, so
    // neither handshake output depends combinationally on an input.
    assign operands_rdy       = (r_state == c_ST_IDLE);
    assign result_val         = (r_state == c_ST_DONE);
    assign result_bits_data   = r_data;
    assign result_bits_cycles = r_cycles;

    // Saturating increment of the compute-cycle counter.
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_k      <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_mode   <= w_mode_nxt;
            r_k      <= w_k_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_mode_nxt   = r_mode;
        w_k_nxt      = r_k;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_cycles_nxt = r_cycles;
        w_term       = 1'b0;
        w_res        = '0;

        case (r_state)
            c_ST_IDLE: begin
                // operands_rdy is implied by being in IDLE.
                if (operands_val) begin
                    w_a_nxt     = operands_bits_A;
                    w_b_nxt     = operands_bits_B;
                    w_mode_nxt  = operands_mode;
                    w_k_nxt     = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_CALC;
                end
            end

            c_ST_CALC: begin
                w_cnt_nxt = w_cnt_inc;
                if (!r_mode) begin
                    // Euclid subtract-swap: keep A >= B, subtract until B hits 0.
                    if (r_a < r_b) begin
                        w_a_nxt = r_b;
                        w_b_nxt = r_a;
                    end else if (r_b != '0) begin
                        w_a_nxt = r_a - r_b;
                    end else begin
                        w_term = 1'b1;
                        w_res  = r_a;
                    end
                end else begin
                    // Stein: strip common factors of two into k, then reduce
                    // odd operands by subtraction; re-apply 2^k at the end.
                    if (r_a == '0) begin
                        w_term = 1'b1;
                        w_res  = r_b << r_k;
                    end else if (r_b == '0) begin
                        w_term = 1'b1;
                        w_res  = r_a << r_k;
                    end else if (!r_a[0] && !r_b[0]) begin
                        w_a_nxt = r_a >> 1;
                        w_b_nxt = r_b >> 1;
                        w_k_nxt = r_k + c_K_ONE;
                    end else if (!r_a[0]) begin
                        w_a_nxt = r_a >> 1;
                    end else if (!r_b[0]) begin
                        w_b_nxt = r_b >> 1;
                    end else if (r_a >= r_b) begin
                        w_a_nxt = r_a - r_b;
                    end else begin
                        w_b_nxt = r_b - r_a;
                    end
                end

                if (w_term) begin
                    // The reported count includes this terminating cycle.
                    w_data_nxt   = w_res;
                    w_cycles_nxt = w_cnt_inc;
                    w_state_nxt  = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                if (result_rdy) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit_multimode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_gcd_unit_multimode
// Purpose  : Self-checking bench for gcd_unit_multimode. Two instances are
//            used: the default W=16/CW=8 build and a W=32/CW=4 build. Expected
//            results are queued when operands are driven and compared when
//            the selected instance presents its result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_unit_multimode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_mode;
    logic        in_val;
    logic        res_rdy;
    logic        use32;

    logic        val16_in;
    logic        val32_in;
    logic        rdy16;
    logic        rdy32;
    logic [15:0] data16;
    logic [31:0] data32;
    logic [7:0]  cyc16;
    logic [3:0]  cyc32;
    logic        rv16;
    logic        rv32;

    logic [31:0] obs_data;
    logic [7:0]  obs_cyc;
    logic        obs_rdy;
    logic        obs_val;

    always #5 clk = ~clk;

    assign val16_in = in_val & ~use32;
    assign val32_in = in_val & use32;
    assign obs_data = use32 ? data32 : {16'h0000, data16};
    assign obs_cyc  = use32 ? {4'h0, cyc32} : cyc16;
    assign obs_rdy  = use32 ? rdy32 : rdy16;
    assign obs_val  = use32 ? rv32 : rv16;

    gcd_unit_multimode #(.W(16), .CW(8)) u_dut16 (
        .clk                (clk),
        .reset              (reset),
        .operands_bits_A    (in_a[15:0]),
        .operands_bits_B    (in_b[15:0]),
        .operands_mode      (in_mode),
        .operands_val       (val16_in),
        .operands_rdy       (rdy16),
        .result_bits_data   (data16),
        .result_bits_cycles (cyc16),
        .result_val         (rv16),
        .result_rdy         (res_rdy)
    );

    gcd_unit_multimode #(.W(32), .CW(4)) u_dut32 (
        .clk                (clk),
        .reset              (reset),
        .operands_bits_A    (in_a),
        .operands_bits_B    (in_b),
        .operands_mode      (in_mode),
        .operands_val       (val32_in),
        .operands_rdy       (rdy32),
        .result_bits_data   (data32),
        .result_bits_cycles (cyc32),
        .result_val         (rv32),
        .result_rdy         (res_rdy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // Number of compute cycles the algorithm needs, terminating cycle included.
    function automatic int model_steps(input logic [31:0] a0, input logic [31:0] b0,
                                       input logic mode);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        int          n;
        a = a0;
        b = b0;
        n = 0;
        while (n < 100000) begin
            n++;
            if (!mode) begin
                if (a < b) begin
                    t = a; a = b; b = t;
                end else if (b != 0) begin
                    a = a - b;
                end else begin
                    return n;
                end
            end else begin
                if (a == 0 || b == 0) return n;
                else if (!a[0] && !b[0]) begin a = a >> 1; b = b >> 1; end
                else if (!a[0]) a = a >> 1;
                else if (!b[0]) b = b >> 1;
                else if (a >= b) a = a - b;
                else b = b - a;
            end
        end
        return n;
    endfunction

    // Queue the expectation, then fire the operands on the selected instance.
    // exp_cyc < 0 means take the (saturated) count from the step model.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic mode,
                        input logic [31:0] exp_data, input int exp_cyc, output bit ok);
        exp_t e;
        int   n;
        int   cmax;
        int   t;
        n      = model_steps(a, b, mode);
        cmax   = use32 ? 15 : 255;
        e.data = exp_data;
        e.lat  = n;
        e.cyc  = (exp_cyc >= 0) ? 8'(exp_cyc) : 8'((n > cmax) ? cmax : n);
        sb.push_back(e);
        @(negedge clk);
        in_a    = a;
        in_b    = b;
        in_mode = mode;
        in_val  = 1'b1;
        t = 0;
        while (!obs_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = obs_rdy;
        @(posedge clk);
        #1;
        in_val = 1'b0;
    endtask

    // Count edges from the fire edge until result_val is seen.
    task automatic await_result(output int lat, output bit ok, output logic rdy_busy);
        lat      = 0;
        rdy_busy = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) rdy_busy = obs_rdy;
        end while (!obs_val && lat < 1000);
        ok = obs_val;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_a    = '0;
        in_b    = '0;
        in_mode = 1'b0;
        in_val  = 1'b0;
        res_rdy = 1'b1;
        use32   = 1'b0;
        #1;
        checks++;
        if (rdy16 !== 1'b1 || rdy32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b/%b want 1/1", rdy16, rdy32);
        end
        checks++;
        if (rv16 !== 1'b0 || rv32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_val: got %b/%b want 0/0", rv16, rv32);
        end
        checks++;
        if (data16 !== 16'h0 || data32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 0/0", data16, data32);
        end
        checks++;
        if (cyc16 !== 8'h0 || cyc32 !== 4'h0) begin
            errors++;
            $display("FAIL reset_cycles: got %h/%h want 0/0", cyc16, cyc32);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs a table of transactions on the selected instance, result_rdy high.
    task automatic test_table(input string nm, input logic [31:0] ta[], input logic [31:0] tb[],
                              input logic tm[], input logic [31:0] td[], input int tc[]);
        int   lat;
        bit   ok_s;
        bit   ok_r;
        logic busy;
        exp_t e;
        for (int i = 0; i < ta.size(); i++) begin
            send(ta[i], tb[i], tm[i], td[i], tc[i], ok_s);
            await_result(lat, ok_r, busy);
            e = sb.pop_front();
            checks++;
            if (!(ok_s && ok_r)) begin
                errors++;
                $display("FAIL %s[%0d] handshake timeout: fire=%b result=%b want 1/1", nm, i, ok_s, ok_r);
            end else begin
                checks++;
                if (obs_data !== e.data) begin
                    errors++;
                    $display("FAIL %s[%0d] data: got %0d want %0d", nm, i, obs_data, e.data);
                end
                checks++;
                if (obs_cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL %s[%0d] cycles: got %0d want %0d", nm, i, obs_cyc, e.cyc);
                end
                checks++;
                if (lat != e.lat) begin
                    errors++;
                    $display("FAIL %s[%0d] latency: got %0d want %0d", nm, i, lat, e.lat);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s[%0d] rdy_in_calc: got %b want 0", nm, i, busy);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (obs_val !== 1'b0 || obs_rdy !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] after_fire: val=%b rdy=%b want 0/1", nm, i, obs_val, obs_rdy);
            end
        end
    endtask

    task automatic test_back_to_back();
        use32 = 1'b0;
        test_table("euclid_b2b",
                   '{27, 21, 25, 19, 250, 5}, '{15, 49, 30, 27, 190, 250},
                   '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                   '{3, 7, 5, 1, 10, 5}, '{-1, -1, -1, -1, -1, -1});
    endtask

    task automatic test_edges();
        use32 = 1'b0;
        test_table("edges16",
                   '{40, 0, 40, 0, 250}, '{40, 0, 40, 7, 190},
                   '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                   '{40, 0, 40, 7, 10}, '{3, 1, 5, 1, -1});
    endtask

    task automatic test_wide();
        use32 = 1'b1;
        test_table("wide32",
                   '{32'hFFFF_FFFE, 250}, '{32'h8000_0000, 1},
                   '{1'b1, 1'b0}, '{2, 1}, '{-1, 15});
        use32 = 1'b0;
    endtask

    task automatic test_backpressure();
        int   lat;
        bit   ok_s;
        bit   ok_r;
        logic busy;
        exp_t e;
        use32 = 1'b0;
        @(negedge clk);
        res_rdy = 1'b0;
        send(21, 49, 1'b0, 7, -1, ok_s);
        await_result(lat, ok_r, busy);
        e = sb.pop_front();
        checks++;
        if (!(ok_s && ok_r)) begin
            errors++;
            $display("FAIL bp handshake timeout: fire=%b result=%b want 1/1", ok_s, ok_r);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_val !== 1'b1 || obs_rdy !== 1'b0 || obs_data !== e.data || obs_cyc !== e.cyc) begin
                errors++;
                $display("FAIL bp_hold[%0d]: val=%b rdy=%b data=%0d cyc=%0d want 1/0/%0d/%0d",
                         i, obs_val, obs_rdy, obs_data, obs_cyc, e.data, e.cyc);
            end
        end
        @(negedge clk);
        res_rdy = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs_val !== 1'b0 || obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: val=%b rdy=%b want 0/1", obs_val, obs_rdy);
        end
    endtask

    task automatic test_reset_midop();
        bit   ok_s;
        exp_t e;
        use32 = 1'b0;
        send(250, 1, 1'b0, 1, -1, ok_s);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (obs_rdy !== 1'b1 || obs_val !== 1'b0 || obs_data !== 32'h0 || obs_cyc !== 8'h0) begin
            errors++;
            $display("FAIL reset_midop: rdy=%b val=%b data=%0d cyc=%0d want 1/0/0/0",
                     obs_rdy, obs_val, obs_data, obs_cyc);
        end
        // The in-flight operands are lost, so their expectation is dropped.
        e = sb.pop_front();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_val !== 1'b0 || obs_rdy !== 1'b1) begin
                errors++;
                $display("FAIL stale_after_reset[%0d]: val=%b rdy=%b want 0/1", i, obs_val, obs_rdy);
            end
        end
        test_table("post_reset", '{27}, '{15}, '{1'b0}, '{3}, '{-1});
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_edges();
        test_wide();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
